// File: rtl/md5_block_engine_if.sv
// Handshake/data bundle between the datapath and md5_block_engine.
// Optional `abort` line exists only when MD5_ABORT_EN is defined.
interface md5_block_engine_if;
    logic         start;
    logic [127:0] chain_in;
    logic [511:0] message;
    logic         busy;
    logic         done;
    logic [127:0] digest_out;
`ifdef MD5_ABORT_EN
    logic         abort;
`endif

    modport master (
`ifdef MD5_ABORT_EN
        output abort,
`endif
        output start, chain_in, message,
        input  busy, done, digest_out
    );

    modport slave (
`ifdef MD5_ABORT_EN
        input  abort,
`endif
        input  start, chain_in, message,
        output busy, done, digest_out
    );
endinterface

// File: rtl/md5_block_engine.sv
// Iterative MD5 compression: one 512-bit block, one step per clock,
// 64 steps, then the chaining value is added back in.
// Optional feature macro: MD5_ABORT_EN (adds an abort input on the interface).
module md5_block_engine (
    input  logic               clk,
    input  logic               reset,
    md5_block_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    // K[i] = floor(|sin(i+1)| * 2^32)
    localparam logic [31:0] K_ROM [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts, indexed [round][step mod 4]
    localparam logic [4:0] SHIFT [0:3][0:3] = '{
        '{5'd7, 5'd12, 5'd17, 5'd22},
        '{5'd5, 5'd9,  5'd14, 5'd20},
        '{5'd4, 5'd11, 5'd16, 5'd23},
        '{5'd6, 5'd10, 5'd15, 5'd21}
    };

    state_t       r_state, w_state_nxt;
    logic [5:0]   r_i;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [127:0] r_chain;
    logic [511:0] r_msg;
    logic         r_done;
    logic [127:0] r_digest;

    logic         w_abort, w_accept, w_step, w_finish;
    logic [31:0]  w_f, w_k, w_m, w_sum, w_rot, w_b_nxt;
    logic [3:0]   w_g;
    logic [4:0]   w_s;

`ifdef MD5_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next-state and step/accept/finish strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_i == 6'd63) w_state_nxt = FINAL;
                end
            end
            FINAL: begin
                w_state_nxt = IDLE;
                w_finish    = !w_abort;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Round function and message-word index for the current step
    always_comb begin
        w_f = 32'h0;
        w_g = 4'h0;
        case (r_i[5:4])
            2'd0: begin
                w_f = (r_b & r_c) | (~r_b & r_d);
                w_g = r_i[3:0];
            end
            2'd1: begin
                w_f = (r_d & r_b) | (~r_d & r_c);
                w_g = r_i[3:0] * 4'd5 + 4'd1;
            end
            2'd2: begin
                w_f = r_b ^ r_c ^ r_d;
                w_g = r_i[3:0] * 4'd3 + 4'd5;
            end
            default: begin
                w_f = r_c ^ (r_b | ~r_d);
                w_g = r_i[3:0] * 4'd7;
            end
        endcase
    end

    assign w_k     = K_ROM[r_i];
    assign w_s     = SHIFT[r_i[5:4]][r_i[1:0]];
    assign w_m     = r_msg[{w_g, 5'b0} +: 32];
    assign w_sum   = r_a + w_f + w_k + w_m;
    assign w_rot   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
    assign w_b_nxt = r_b + w_rot;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Working registers, step counter and digest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i      <= 6'd0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_c      <= 32'h0;
            r_d      <= 32'h0;
            r_chain  <= 128'h0;
            r_msg    <= 512'h0;
            r_done   <= 1'b0;
            r_digest <= 128'h0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_chain <= bus.chain_in;
                r_msg   <= bus.message;
                r_a     <= bus.chain_in[31:0];
                r_b     <= bus.chain_in[63:32];
                r_c     <= bus.chain_in[95:64];
                r_d     <= bus.chain_in[127:96];
                r_i     <= 6'd0;
            end else if (w_step) begin
                r_a <= r_d;
                r_b <= w_b_nxt;
                r_c <= r_b;
                r_d <= r_c;
                r_i <= r_i + 6'd1;
            end
            // Per-word add; no carry crosses word boundaries
            if (w_finish) begin
                r_digest <= {r_chain[127:96] + r_d, r_chain[95:64] + r_c,
                             r_chain[63:32]  + r_b, r_chain[31:0]  + r_a};
            end
        end
    end

    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.digest_out = r_digest;
endmodule
